mdu_ex: RTL and testbench
=========================

MDU_EX -- requirements
Module: mdu_ex

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving operand and HI/LO width.
REQ-002 The block SHALL have parameter CNTW, default 5, giving iteration-counter width (XLEN = 2**CNTW).
REQ-003 clk  input  1  rising-edge clock; the block SHALL use one clock only.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  EX-stage request to begin a multiply/divide, qualified by op.
REQ-006 op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 a  input  XLEN  rs operand from the ID/EX register (multiplicand/dividend).
REQ-008 b  input  XLEN  rt operand from the ID/EX register (multiplier/divisor).
REQ-009 mthi, mtlo  input  1 each  direct write of wdata into HI or LO.
REQ-010 wdata  input  XLEN  data for mthi/mtlo.
REQ-011 rd_hilo  input  1  EX stage holds MFHI/MFLO this cycle.
REQ-012 abort  input  1  pipeline flush; cancels any operation in progress.
REQ-013 hi, lo  output  XLEN each  architectural HI/LO registers.
REQ-014 busy  output  1  operation in progress.
REQ-015 stall  output  1  combinational request to freeze IF/ID and ID/EX and bubble EX/MEM.

Function
REQ-016 The FSM SHALL have states IDLE, CALC and FIX.
REQ-017 IDLE->CALC SHALL occur on start=1 with abort=0; CALC SHALL last exactly XLEN cycles; FIX SHALL last one cycle; FIX->IDLE follows.
REQ-018 On start, the block SHALL latch magnitudes of a and b (two's-complement negate when op is signed and the operand MSB is 1), the result-sign flags, op, and clear the counter.
REQ-019 Multiply SHALL be radix-2 shift-add, one bit per CALC cycle, producing a 2*XLEN product.
REQ-020 Divide SHALL be radix-2 restoring, one quotient bit per CALC cycle.
REQ-021 In FIX, the block SHALL negate the product if the operand signs differ (signed only), negate the quotient if the operand signs differ, and give the remainder the sign of the dividend.
REQ-022 At the FIX clock edge, the block SHALL write HI = product[2*XLEN-1:XLEN] / remainder and LO = product[XLEN-1:0] / quotient.
REQ-023 Latency: with start sampled at edge 0, busy SHALL be 1 for XLEN+1 cycles and HI/LO SHALL be valid after edge XLEN+1.
REQ-024 busy SHALL be 1 in CALC and FIX and 0 in IDLE.
REQ-025 stall SHALL equal busy & (start | rd_hilo | mthi | mtlo); start, mthi and mtlo arriving while busy SHALL be held by the stall and not acted on.
REQ-026 Divide by zero SHALL give LO = all ones and HI = the dividend unchanged, with the same latency.
REQ-027 Signed 0x80000000 / 0xFFFFFFFF SHALL give LO = 0x80000000 and HI = 0.
REQ-028 In IDLE, mthi/mtlo SHALL write HI/LO at the next edge; if start is also 1, start SHALL win and the write SHALL be dropped.
REQ-029 abort SHALL force IDLE at the next edge from any state, leave HI/LO unchanged, and suppress a start in the same cycle.
REQ-030 HI/LO SHALL be unchanged except by FIX, mthi/mtlo or reset.

Reset
REQ-031 On rst_n=0, the block SHALL asynchronously clear state to IDLE and hi, lo, busy, counter and all datapath registers to 0.
REQ-032 stall SHALL read 0 during reset.
REQ-033 Reset deassertion mid-operation SHALL leave the block in IDLE with no pending result.

Structure
REQ-034 Op encodings (MULT/MULTU/DIV/DIVU) and FSM state encodings SHALL live in shared package mips_pkg.
REQ-035 The iterative datapath (shift-add/restoring step plus counter) SHALL be sub-module mdu_iter; mdu_ex SHALL hold the FSM, sign handling and HI/LO.

Verification
REQ-036 MULT a=0xFFFFFFFD (-3), b=5 -> after 33 busy cycles HI=0xFFFFFFFF, LO=0xFFFFFFF1; MULTU 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-037 DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/2 -> LO=3, HI=1; DIVU 100/0 -> LO=0xFFFFFFFF, HI=0x00000064.
REQ-038 rd_hilo=1 during busy -> stall=1 the same cycle; stall=0 in the cycle after FIX, and MFLO then reads the new LO.
REQ-039 abort at CALC cycle 10 after HI=0x11, LO=0x22 preloaded by mthi/mtlo -> busy=0 next cycle, HI=0x11, LO=0x22.
REQ-040 rst_n pulsed low mid-CALC -> hi=lo=0 and busy=0 immediately, without a clock edge; a new start afterwards completes with correct results.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MDU encodings: operation codes and FSM states.
package mips_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10
    } state_t;

endpackage

// File: rtl/mdu_iter.sv
// Iterative MDU datapath: one shift-add (multiply) or restoring (divide)
// step per cycle on unsigned magnitudes, plus the iteration counter.
module mdu_iter #(
    parameter int XLEN = 32,
    parameter int CNTW = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            step,
    input  logic            is_div,
    input  logic [XLEN-1:0] a_mag,
    input  logic [XLEN-1:0] b_mag,
    output logic [XLEN-1:0] acc_hi,
    output logic [XLEN-1:0] acc_lo,
    output logic            last
);

    logic [XLEN-1:0] b_r;
    logic [CNTW-1:0] cnt;
    logic [XLEN-1:0] hi_n;
    logic [XLEN-1:0] lo_n;
    logic [XLEN:0]   sum;
    logic [XLEN:0]   shifted;
    logic [XLEN+1:0] diff;

    // acc_hi:acc_lo is the running product for multiply, and
    // remainder:dividend/quotient for divide; both start with a in acc_lo.
    always_comb begin
        sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_r} : '0);
        shifted = {acc_hi, acc_lo[XLEN-1]};
        diff    = {1'b0, shifted} - {2'b00, b_r};
        hi_n    = acc_hi;
        lo_n    = acc_lo;
        if (is_div) begin
            if (!diff[XLEN+1]) begin
                hi_n = diff[XLEN-1:0];
                lo_n = {acc_lo[XLEN-2:0], 1'b1};
            end else begin
                hi_n = shifted[XLEN-1:0];
                lo_n = {acc_lo[XLEN-2:0], 1'b0};
            end
        end else begin
            {hi_n, lo_n} = {sum, acc_lo[XLEN-1:1]};
        end
    end

    // Load operands / advance one iteration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_hi <= '0;
            acc_lo <= '0;
            b_r    <= '0;
            cnt    <= '0;
        end else if (load) begin
            acc_hi <= '0;
            acc_lo <= a_mag;
            b_r    <= b_mag;
            cnt    <= '0;
        end else if (step) begin
            acc_hi <= hi_n;
            acc_lo <= lo_n;
            cnt    <= cnt + 1'b1;
        end
    end

    assign last = (cnt == '1);

endmodule

// File: rtl/mdu_ex.sv
// EX-stage multiply/divide unit: control FSM, sign handling and HI/LO.
module mdu_ex
    import mips_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int CNTW = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            mthi,
    input  logic            mtlo,
    input  logic [XLEN-1:0] wdata,
    input  logic            rd_hilo,
    input  logic            abort,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            busy,
    output logic            stall
);

    state_t          state, state_n;
    logic            load, step, fix;
    logic            op_signed, op_div;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_r, neg_a_r, neg_b_r, div0_r;
    logic [XLEN-1:0] it_hi, it_lo;
    logic            last;
    logic [2*XLEN-1:0] prod, prod_f;
    logic [XLEN-1:0] fix_hi, fix_lo;

    assign op_signed = (op_t'(op) == OP_MULT) || (op_t'(op) == OP_DIV);
    assign op_div    = (op_t'(op) == OP_DIV)  || (op_t'(op) == OP_DIVU);
    assign a_neg     = op_signed & a[XLEN-1];
    assign b_neg     = op_signed & b[XLEN-1];
    assign a_mag     = a_neg ? -a : a;
    assign b_mag     = b_neg ? -b : b;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    // Next state and step controls.
    always_comb begin
        state_n = state;
        load    = 1'b0;
        step    = 1'b0;
        fix     = 1'b0;
        if (abort) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    state_n = S_CALC;
                    load    = 1'b1;
                end
                S_CALC: begin
                    step = 1'b1;
                    if (last) state_n = S_FIX;
                end
                S_FIX: begin
                    fix     = 1'b1;
                    state_n = S_IDLE;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    assign busy  = (state != S_IDLE);
    assign stall = busy & (start | rd_hilo | mthi | mtlo);

    // Latch operation kind and sign flags at start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_r   <= 1'b0;
            neg_a_r <= 1'b0;
            neg_b_r <= 1'b0;
            div0_r  <= 1'b0;
        end else if (load) begin
            div_r   <= op_div;
            neg_a_r <= a_neg;
            neg_b_r <= b_neg;
            div0_r  <= (b == '0);
        end
    end

    mdu_iter #(.XLEN(XLEN), .CNTW(CNTW)) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .step   (step),
        .is_div (div_r),
        .a_mag  (a_mag),
        .b_mag  (b_mag),
        .acc_hi (it_hi),
        .acc_lo (it_lo),
        .last   (last)
    );

    // Sign correction of the unsigned result. Divide by zero forces an
    // all-ones quotient; the remainder path already yields the dividend.
    always_comb begin
        prod   = {it_hi, it_lo};
        prod_f = (neg_a_r ^ neg_b_r) ? -prod : prod;
        if (div_r) begin
            fix_hi = neg_a_r ? -it_hi : it_hi;
            fix_lo = div0_r ? '1 : ((neg_a_r ^ neg_b_r) ? -it_lo : it_lo);
        end else begin
            fix_hi = prod_f[2*XLEN-1:XLEN];
            fix_lo = prod_f[XLEN-1:0];
        end
    end

    // HI/LO: written by FIX, or by mthi/mtlo when idle and no start wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi <= '0;
            lo <= '0;
        end else if (fix) begin
            hi <= fix_hi;
            lo <= fix_lo;
        end else if (state == S_IDLE && !abort && !start) begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
        end
    end

endmodule

// File: tb/tb_mdu_ex.sv
// Self-checking bench for mdu_ex: directed vector table, corner-case
// sequences, and random operations against an arithmetic reference model.
module tb_mdu_ex;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0, b = '0, wdata = '0;
    logic        mthi = 1'b0, mtlo = 1'b0, rd_hilo = 1'b0, abort = 1'b0;
    logic [31:0] hi, lo;
    logic        busy, stall;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    mdu_ex #(.XLEN(32), .CNTW(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .rd_hilo(rd_hilo),
        .abort(abort), .hi(hi), .lo(lo), .busy(busy), .stall(stall)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Reference: plain arithmetic on the architectural definition of each op.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy;
        int q, r;
        case (o)
            2'b00: begin sx = longint'($signed(x)); sy = longint'($signed(y)); return 64'(sx * sy); end
            2'b01: return {32'b0, x} * {32'b0, y};
            2'b10: begin
                if (y == 0) return {x, 32'hFFFFFFFF};
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
                q = $signed(x) / $signed(y);
                r = $signed(x) % $signed(y);
                return {r, q};
            end
            default: begin
                if (y == 0) return {x, 32'hFFFFFFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, output int cyc);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (busy && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    initial begin
        int cyc;
        logic [63:0] m;
        logic [31:0] rx, ry;
        logic [1:0]  ro;

        vecs[0]  = '{2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[1]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{2'b11, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
        vecs[4]  = '{2'b11, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF};
        vecs[5]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[6]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[7]  = '{2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[8]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[9]  = '{2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
        vecs[10] = '{2'b11, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};

        // Reset state, with a stall-qualifying input active.
        rd_hilo = 1'b1;
        #2;
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);
        check("reset_busy", {31'b0, busy}, 32'h0);
        check("reset_stall", {31'b0, stall}, 32'h0);
        rd_hilo = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vector table.
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc);
            check($sformatf("vec%0d_busy_cycles", i), cyc, 32'd33);
            check($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
            check($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
        end

        // rd_hilo / mtlo while busy stall; MFLO after FIX sees the new LO.
        @(negedge clk);
        op = 2'b11; a = 32'd1000; b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0; rd_hilo = 1'b1;
        #1 check("stall_rd_hilo", {31'b0, stall}, 32'h1);
        @(negedge clk);
        mtlo = 1'b1; wdata = 32'hDEAD;
        #1 check("stall_mtlo", {31'b0, stall}, 32'h1);
        @(negedge clk);
        mtlo = 1'b0;
        cyc = 0;
        while (busy && cyc < 200) begin cyc++; @(negedge clk); end
        check("stall_after_fix", {31'b0, stall}, 32'h0);
        check("mflo_new_lo", lo, 32'd142);
        check("mfhi_new_hi", hi, 32'd6);
        rd_hilo = 1'b0;

        // mthi/mtlo in idle.
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h11;
        @(negedge clk);
        mtlo = 1'b1; mthi = 1'b0; wdata = 32'h22;
        @(negedge clk);
        mtlo = 1'b0;
        check("mthi_idle", hi, 32'h11);
        check("mtlo_idle", lo, 32'h22);

        // start wins over a same-cycle mthi.
        op = 2'b01; a = 32'd2; b = 32'd3; start = 1'b1; mthi = 1'b1; wdata = 32'h99;
        @(negedge clk);
        start = 1'b0; mthi = 1'b0;
        check("start_wins_hi_kept", hi, 32'h11);
        check("start_wins_busy", {31'b0, busy}, 32'h1);
        cyc = 0;
        while (busy && cyc < 200) begin cyc++; @(negedge clk); end
        check("start_wins_hi", hi, 32'h0);
        check("start_wins_lo", lo, 32'd6);

        // Abort at CALC cycle 10 with preloaded HI/LO.
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h11;
        @(negedge clk);
        mthi = 1'b0; wdata = 32'h22;
        @(negedge clk);
        mtlo = 1'b0;
        op = 2'b01; a = 32'd7; b = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", {31'b0, busy}, 32'h0);
        check("abort_hi", hi, 32'h11);
        check("abort_lo", lo, 32'h22);
        repeat (40) @(negedge clk);
        check("abort_no_late_hi", hi, 32'h11);
        check("abort_no_late_lo", lo, 32'h22);

        // abort suppresses a same-cycle start.
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("abort_start_busy", {31'b0, busy}, 32'h0);

        // Asynchronous reset mid-CALC.
        op = 2'b10; a = 32'd50; b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0; rd_hilo = 1'b1;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_hi", hi, 32'h0);
        check("async_rst_lo", lo, 32'h0);
        check("async_rst_busy", {31'b0, busy}, 32'h0);
        check("async_rst_stall", {31'b0, stall}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1; rd_hilo = 1'b0;
        repeat (40) @(negedge clk);
        check("post_rst_busy", {31'b0, busy}, 32'h0);
        check("post_rst_lo", lo, 32'h0);
        run_op(2'b10, 32'hFFFFFF9C, 32'd7, cyc);
        check("post_rst_cycles", cyc, 32'd33);
        check("post_rst_hi", hi, 32'hFFFFFFFE);
        check("post_rst_lo2", lo, 32'hFFFFFFF2);

        // Random operations, biased towards edge operands.
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(3));
            rx = $urandom;
            ry = $urandom;
            case ($urandom_range(7))
                0: ry = 32'h0;
                1: ry = 32'hFFFFFFFF;
                2: rx = 32'h80000000;
                3: ry = 32'($urandom_range(15));
                default: ;
            endcase
            m = model(ro, rx, ry);
            run_op(ro, rx, ry, cyc);
            check($sformatf("rand%0d_op%0d_cycles", i, ro), cyc, 32'd33);
            check($sformatf("rand%0d_op%0d_%08h_%08h_hi", i, ro, rx, ry), hi, m[63:32]);
            check($sformatf("rand%0d_op%0d_%08h_%08h_lo", i, ro, rx, ry), lo, m[31:0]);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
